// File: rtl/rns_mm_pkg.sv
// Shared constants and types for the residue-digit modular multiplier sharing logic.
package rns_mm_pkg;

    localparam int DATA_WIDTH = 18;
    localparam int MODULUS    = 177147;
    localparam int MM_LATENCY = 6;
    localparam int MAX_TAG_W  = 3;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            result++;
        end
        return result;
    endfunction

    typedef struct packed {
        logic [MAX_TAG_W-1:0]  tag;
        logic [DATA_WIDTH-1:0] data;
    } tagged_word_t;

endpackage

// File: rtl/mm_result_fifo.sv
// Synchronous first-word-fall-through FIFO holding {tag, product} words with an occupancy count.
module mm_result_fifo
    import rns_mm_pkg::*;
#(
    parameter int  WIDTH = DATA_WIDTH + 2,
    parameter int  DEPTH = 8,
    localparam int PTR_W = (DEPTH > 1) ? clog2(DEPTH) : 1,
    localparam int CNT_W = clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count
);

    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_pop;

    assign do_pop = pop && (count != '0);

    // NOTE: storage is deliberately not reset; the count decides what is visible.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head_data = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/modmult_share_ctrl.sv
// Round-robin time-sharing of one fixed-latency constant modular multiplier between N requester lanes.
module modmult_share_ctrl
    import rns_mm_pkg::*;
#(
    parameter int  N_REQ      = 4,
    parameter int  FIFO_DEPTH = 8,
    parameter int  TAG_W      = (N_REQ > 1) ? clog2(N_REQ) : 1,
    localparam int CNT_W      = clog2(FIFO_DEPTH + 1)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_REQ-1:0]            req_valid,
    input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]            req_ready,
    output logic [DATA_WIDTH-1:0]       mm_op,
    input  logic [DATA_WIDTH-1:0]       mm_result,
    output logic                        out_valid,
    output logic [DATA_WIDTH-1:0]       out_data,
    output logic [TAG_W-1:0]            out_tag,
    input  logic                        out_ready,
    output logic                        range_err,
    output logic [CNT_W-1:0]            inflight
);

    localparam logic [DATA_WIDTH-1:0] MOD_V   = DATA_WIDTH'(MODULUS);
    localparam logic [CNT_W-1:0]      DEPTH_V = CNT_W'(FIFO_DEPTH);
    localparam logic [TAG_W:0]        NREQ_V  = (TAG_W + 1)'(N_REQ);

    logic [DATA_WIDTH-1:0] lane_data [N_REQ];
    logic [TAG_W-1:0]      rr_last;
    logic [TAG_W-1:0]      gnt_idx;
    logic                  gnt_found;
    logic [TAG_W:0]        cand;
    logic                  can_issue;
    logic                  issue;

    logic [MM_LATENCY:0]              sh_valid;
    logic [MM_LATENCY:0][TAG_W-1:0]   sh_tag;

    logic                        fifo_push;
    logic                        fifo_pop;
    logic [DATA_WIDTH+TAG_W-1:0] fifo_head;
    logic [CNT_W-1:0]            fifo_count;

    for (genvar i = 0; i < N_REQ; i++) begin : g_lane
        assign lane_data[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    assign can_issue = (inflight < DEPTH_V);

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = rr_last;
        cand      = '0;
        req_ready = '0;
        if (can_issue) begin
            for (int k = 1; k <= N_REQ; k++) begin
                cand = {1'b0, rr_last} + (TAG_W + 1)'(k);
                if (cand >= NREQ_V) begin
                    cand = cand - NREQ_V;
                end
                if (!gnt_found && req_valid[cand[TAG_W-1:0]]) begin
                    gnt_found = 1'b1;
                    gnt_idx   = cand[TAG_W-1:0];
                end
            end
        end
        if (gnt_found) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    assign issue = gnt_found;

    // NOTE: state registers use non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            mm_op     <= '0;
            rr_last   <= TAG_W'(N_REQ - 1);
            range_err <= 1'b0;
            inflight  <= '0;
            sh_valid  <= '0;
        end else begin
            if (issue) begin
                mm_op   <= lane_data[gnt_idx];
                rr_last <= gnt_idx;
                if (lane_data[gnt_idx] >= MOD_V) begin
                    range_err <= 1'b1;
                end
            end
            sh_valid <= {sh_valid[MM_LATENCY-1:0], issue};
            case ({issue, fifo_pop})
                2'b10:   inflight <= inflight + 1'b1;
                2'b01:   inflight <= inflight - 1'b1;
                default: inflight <= inflight;
            endcase
        end
    end

    // Tags only matter where the matching valid bit is set, so they need no reset.
    always_ff @(posedge clk) begin
        sh_tag <= {sh_tag[MM_LATENCY-1:0], gnt_idx};
    end

    assign fifo_push = sh_valid[MM_LATENCY];
    assign fifo_pop  = out_valid && out_ready;

    mm_result_fifo #(
        .WIDTH (DATA_WIDTH + TAG_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data ({sh_tag[MM_LATENCY], mm_result}),
        .pop       (fifo_pop),
        .head_data (fifo_head),
        .count     (fifo_count)
    );

    assign out_valid = (fifo_count != '0);
    assign out_data  = fifo_head[DATA_WIDTH-1:0];
    assign out_tag   = fifo_head[DATA_WIDTH +: TAG_W];

endmodule

// File: tb/tb_modmult_share_ctrl.sv
// Scoreboard bench for modmult_share_ctrl with a behavioural constant modular multiplier attached.
module tb_modmult_share_ctrl;
    import rns_mm_pkg::*;

    localparam int    N_REQ      = 4;
    localparam int    FIFO_DEPTH = 8;
    localparam int    TAG_W      = 2;
    localparam int    CNT_W      = 4;
    localparam longint C_MULT    = 54321;

    logic                        clk = 1'b0;
    logic                        reset;
    logic [N_REQ-1:0]            req_valid;
    logic [N_REQ*DATA_WIDTH-1:0] req_data;
    logic [N_REQ-1:0]            req_ready;
    logic [DATA_WIDTH-1:0]       mm_op;
    logic [DATA_WIDTH-1:0]       mm_result;
    logic                        out_valid;
    logic [DATA_WIDTH-1:0]       out_data;
    logic [TAG_W-1:0]            out_tag;
    logic                        out_ready;
    logic                        range_err;
    logic [CNT_W-1:0]            inflight;

    int checks = 0;
    int errors = 0;
    tagged_word_t exp_q[$];

    modmult_share_ctrl #(.N_REQ(N_REQ), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .mm_op     (mm_op),
        .mm_result (mm_result),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_tag   (out_tag),
        .out_ready (out_ready),
        .range_err (range_err),
        .inflight  (inflight)
    );

    always #5 clk = ~clk;

    function automatic logic [DATA_WIDTH-1:0] golden(input logic [DATA_WIDTH-1:0] x);
        longint p;
        p = (longint'(x) * C_MULT) % longint'(MODULUS);
        return DATA_WIDTH'(p);
    endfunction

    // Attached multiplier: no reset, no stall, result MM_LATENCY edges after mm_op is registered.
    logic [DATA_WIDTH-1:0] mm_pipe [MM_LATENCY];
    always @(posedge clk) begin
        mm_pipe[0] <= golden(mm_op);
        for (int i = 1; i < MM_LATENCY; i++) mm_pipe[i] <= mm_pipe[i-1];
    end
    assign mm_result = mm_pipe[MM_LATENCY-1];

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Issue monitor: every completed handshake pushes its expected result.
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    tagged_word_t e;
                    e.tag  = MAX_TAG_W'(i);
                    e.data = golden(req_data[i*DATA_WIDTH +: DATA_WIDTH]);
                    exp_q.push_back(e);
                end
            end
        end
    end

    // Output monitor: every accepted output is compared against the queue head.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output data=%0d tag=%0d", out_data, out_tag);
            end else begin
                tagged_word_t e;
                e = exp_q.pop_front();
                check("out_data", out_data, e.data);
                check("out_tag", out_tag, e.tag);
            end
        end
    end

    // FIFO must never be pushed while full without a simultaneous pop.
    always @(negedge clk) begin
        if (!reset && dut.fifo_push && !dut.fifo_pop && dut.fifo_count == CNT_W'(FIFO_DEPTH)) begin
            errors++;
            $display("FAIL fifo_overflow count=%0d", dut.fifo_count);
        end
        if (!reset && dut.fifo_pop && dut.fifo_count == '0) begin
            errors++;
            $display("FAIL fifo_underflow count=%0d", dut.fifo_count);
        end
    end

    task automatic set_lane(input int lane, input logic [DATA_WIDTH-1:0] value);
        req_data[lane*DATA_WIDTH +: DATA_WIDTH] = value;
    endtask

    task automatic reset_dut();
        reset     = 1'b1;
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic drain(input string name);
        logic done;
        done      = 1'b0;
        req_valid = '0;
        out_ready = 1'b1;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_valid && inflight == '0) done = 1'b1;
        end
        check(name, done, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int n;
        logic [N_REQ-1:0] acc;

        reset     = 1'b1;
        req_valid = '0;
        req_data  = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_req_ready", req_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_tag", out_tag, 0);
        check("rst_range_err", range_err, 0);
        check("rst_inflight", inflight, 0);
        check("rst_mm_op", mm_op, 0);
        @(posedge clk); #1;

        // Single request from lane 1
        out_ready = 1'b1;
        set_lane(1, 18'd1);
        req_valid = 4'b0010;
        @(negedge clk);
        check("single_grant", req_ready, 4'b0010);
        @(posedge clk); #1;
        req_valid = '0;
        lat = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) break;
            @(posedge clk);
            lat++;
        end
        check("single_latency_ok", (lat >= MM_LATENCY + 1 && lat <= MM_LATENCY + 2), 1);
        drain("single_drain");
        check("single_inflight", inflight, 0);

        // All lanes streaming: grants rotate 0,1,2,3
        reset_dut();
        for (int i = 0; i < N_REQ; i++) set_lane(i, DATA_WIDTH'(i));
        req_valid = 4'hF;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check("rr_grant", req_ready, 4'b0001 << (k % 4));
            @(posedge clk); #1;
        end
        drain("rr_drain");

        // Backpressure: credits stop issue at FIFO_DEPTH
        reset_dut();
        for (int i = 0; i < N_REQ; i++) set_lane(i, DATA_WIDTH'(10 * (i + 1)));
        out_ready = 1'b0;
        req_valid = 4'hF;
        n = 0;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            if (req_ready != '0) n++;
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("bp_issue_count", n, FIFO_DEPTH);
        check("bp_ready_low", req_ready, 0);
        check("bp_inflight", inflight, FIFO_DEPTH);
        check("bp_out_valid", out_valid, 1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (req_ready != '0) break;
            @(posedge clk); #1;
            n++;
        end
        check("bp_resumed", (n < 20), 1);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("bp_one_per_cycle", (req_ready != '0), 1);
        end
        @(posedge clk); #1;
        drain("bp_drain");

        // Out-of-range operand sets a sticky flag
        reset_dut();
        set_lane(0, DATA_WIDTH'(MODULUS));
        req_valid = 4'b0001;
        @(negedge clk);
        check("range_grant", req_ready, 4'b0001);
        @(posedge clk); #1;
        req_valid = '0;
        @(negedge clk);
        check("range_err_set", range_err, 1);
        @(posedge clk); #1;
        set_lane(2, 18'd5);
        req_valid = 4'b0100;
        @(posedge clk); #1;
        drain("range_drain");
        check("range_err_sticky", range_err, 1);
        reset_dut();
        @(negedge clk);
        check("range_err_cleared", range_err, 0);
        @(posedge clk); #1;

        // Reset in the middle of traffic flushes everything
        for (int i = 0; i < N_REQ; i++) set_lane(i, DATA_WIDTH'(100 + i));
        req_valid = 4'hF;
        repeat (5) @(posedge clk);
        #1 req_valid = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("flush_out_valid", out_valid, 0);
            @(posedge clk); #1;
        end
        check("flush_inflight", inflight, 0);
        set_lane(3, 18'd7);
        req_valid = 4'b1000;
        @(posedge clk); #1;
        drain("flush_next_op");

        // Random residues with random consumer backpressure
        reset_dut();
        for (int i = 0; i < N_REQ; i++) set_lane(i, DATA_WIDTH'($urandom_range(0, MODULUS - 1)));
        req_valid = 4'hF;
        n = 0;
        for (int cyc = 0; cyc < 5000 && n < 200; cyc++) begin
            @(negedge clk);
            acc = req_valid & req_ready;
            @(posedge clk); #1;
            for (int i = 0; i < N_REQ; i++) begin
                if (acc[i]) begin
                    n++;
                    set_lane(i, DATA_WIDTH'($urandom_range(0, MODULUS - 1)));
                end
            end
            out_ready = 1'($urandom_range(0, 1));
            if (n >= 200) req_valid = '0;
        end
        check("rand_issued", n, 200);
        drain("rand_drain");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
